// File: rtl/fg_pkg.sv
// Shared definitions for the function-generator profile sequencer:
// FSM encoding, configuration-register field positions and profile geometry.
package fg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam int CS_MODE_POS       = 55;
    localparam int OFFSET_POS        = 0;
    localparam int BYTES_PER_PROFILE = 7;

endpackage

// File: rtl/fg_profile_mem.sv
// Byte-writable profile register file with a combinational read port.
// An out-of-range byte or profile index is dropped and flagged one cycle later.
module fg_profile_mem
    import fg_pkg::*;
#(
    parameter int CONFIG_REG_BITWIDTH   = 56,
    parameter int PROFILE_COUNT         = 4,
    parameter int PROFILE_ADDR_BITWIDTH = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             wr_en_i,
    input  logic [PROFILE_ADDR_BITWIDTH+2:0] wr_addr_i,
    input  logic [7:0]                       wr_data_i,
    input  logic [PROFILE_ADDR_BITWIDTH-1:0] rd_idx_i,
    output logic [CONFIG_REG_BITWIDTH-1:0]   rd_data_o,
    output logic                             wr_err_o
);

    logic [CONFIG_REG_BITWIDTH-1:0]   mem_q [PROFILE_COUNT];
    logic [CONFIG_REG_BITWIDTH-1:0]   mem_d [PROFILE_COUNT];
    logic                             wr_err_q;
    logic                             wr_err_d;
    logic [2:0]                       byte_idx;
    logic [PROFILE_ADDR_BITWIDTH-1:0] prof_idx;
    logic                             wr_bad;

    assign byte_idx = wr_addr_i[2:0];
    assign prof_idx = wr_addr_i[PROFILE_ADDR_BITWIDTH+2:3];

    // The profile check only matters when PROFILE_COUNT is not a power of two.
    assign wr_bad = (byte_idx >= 3'(BYTES_PER_PROFILE)) ||
                    (32'(prof_idx) >= 32'(PROFILE_COUNT));

    always_comb begin
        mem_d    = mem_q;
        wr_err_d = wr_en_i && wr_bad;
        if (wr_en_i && !wr_bad) begin
            mem_d[prof_idx][{byte_idx, 3'b000} +: 8] = wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];
    assign wr_err_o  = wr_err_q;

endmodule

// File: rtl/fg_profile_sequencer.sv
// Plays stored generator profiles in order, each for a programmed number of
// generator output strobes, pulsing the generator enable low on every switch.
module fg_profile_sequencer
    import fg_pkg::*;
#(
    parameter int CONFIG_REG_BITWIDTH   = 56,
    parameter int PROFILE_COUNT         = 4,
    parameter int PROFILE_ADDR_BITWIDTH = 2,
    parameter int DWELL_BITWIDTH        = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             wr_en_i,
    input  logic [PROFILE_ADDR_BITWIDTH+2:0] wr_addr_i,
    input  logic [7:0]                       wr_data_i,
    input  logic                             start_i,
    input  logic                             stop_i,
    input  logic                             loop_i,
    input  logic [PROFILE_ADDR_BITWIDTH-1:0] last_profile_i,
    input  logic [DWELL_BITWIDTH-1:0]        dwell_i,
    input  logic                             fg_valid_strb_i,
    output logic [CONFIG_REG_BITWIDTH-1:0]   CR_bus_o,
    output logic                             fg_enable_o,
    output logic [PROFILE_ADDR_BITWIDTH-1:0] active_profile_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             wr_err_o
);

    state_e                           state_q, state_d;
    logic [PROFILE_ADDR_BITWIDTH-1:0] idx_q, idx_d;
    logic [PROFILE_ADDR_BITWIDTH-1:0] last_q, last_d;
    logic [PROFILE_ADDR_BITWIDTH-1:0] active_q, active_d;
    logic                             loop_q, loop_d;
    logic [DWELL_BITWIDTH-1:0]        dwell_q, dwell_d;
    logic [DWELL_BITWIDTH-1:0]        cnt_q, cnt_d;
    logic [CONFIG_REG_BITWIDTH-1:0]   cr_q, cr_d;
    logic                             done_q, done_d;

    logic [CONFIG_REG_BITWIDTH-1:0]   rd_data;
    logic [DWELL_BITWIDTH-1:0]        cnt_inc;
    logic [PROFILE_ADDR_BITWIDTH-1:0] last_clamped;
    logic [DWELL_BITWIDTH-1:0]        dwell_floor;

    fg_profile_mem #(
        .CONFIG_REG_BITWIDTH   (CONFIG_REG_BITWIDTH),
        .PROFILE_COUNT         (PROFILE_COUNT),
        .PROFILE_ADDR_BITWIDTH (PROFILE_ADDR_BITWIDTH)
    ) u_mem (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_idx_i  (idx_q),
        .rd_data_o (rd_data),
        .wr_err_o  (wr_err_o)
    );

    assign cnt_inc      = cnt_q + 1'b1;
    assign last_clamped = (32'(last_profile_i) >= 32'(PROFILE_COUNT)) ?
                          PROFILE_ADDR_BITWIDTH'(PROFILE_COUNT - 1) : last_profile_i;
    assign dwell_floor  = (dwell_i == '0) ? DWELL_BITWIDTH'(1) : dwell_i;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        loop_d   = loop_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        cr_d     = cr_q;
        active_d = active_q;
        done_d   = 1'b0;
        // Stop overrides everything, including a completing dwell.
        if (stop_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        loop_d  = loop_i;
                        last_d  = last_clamped;
                        dwell_d = dwell_floor;
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cr_d     = rd_data;
                    active_d = idx_q;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
                ST_RUN: begin
                    if (fg_valid_strb_i) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == dwell_q) begin
                            if (idx_q < last_q) begin
                                idx_d   = idx_q + 1'b1;
                                state_d = ST_LOAD;
                            end else if (loop_q) begin
                                idx_d   = '0;
                                state_d = ST_LOAD;
                            end else begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            last_q   <= '0;
            loop_q   <= 1'b0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            cr_q     <= '0;
            active_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            loop_q   <= loop_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            cr_q     <= cr_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign CR_bus_o         = cr_q;
    assign fg_enable_o      = (state_q == ST_RUN);
    assign active_profile_o = active_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign done_o           = done_q;

endmodule
